// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-bus slice between the core (master) and the UART
// transmitter (slave).
//   MemWrite  - store strobe
//   DataAdr   - bus address
//   WriteData - store data
//   ReadData  - slave read data (combinational)
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low
//   bus      - mmio_uart_tx_if.slave (MemWrite/DataAdr/WriteData in, ReadData out)
//   tx       - serial line, idle high, registered
//   busy     - FIFO non-empty or frame in progress
//   overflow - sticky: a store hit a full FIFO
// Stores to TX_ADDR queue WriteData[7:0]; STAT_ADDR reads the status word
// {count[12:8], overflow[3], busy[2], empty[1], full[0]}, and a store there
// with bit0 set clears overflow.
// Optional feature: define MMIO_UART_PARITY_EN to append an even-parity bit.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h1000_0000,
  parameter logic [31:0] STAT_ADDR    = 32'h1000_0004,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  mmio_uart_tx_if.slave     bus,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef MMIO_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef MMIO_UART_PARITY_EN
  logic          par_q;
`endif

  logic baud_last, fifo_full, fifo_empty, pop, push_req, push, drop, clr;

  assign baud_last  = (baud == BW'(CLKS_PER_BIT - 1));
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // The head leaves the FIFO when a frame starts, either from idle or
  // straight out of the previous stop bit (no inter-frame gap).
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
  assign push_req   = bus.MemWrite && (bus.DataAdr == TX_ADDR);
  // A same-edge pop frees a slot, so a full FIFO still accepts in that case.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && !push;
  assign clr        = bus.MemWrite && (bus.DataAdr == STAT_ADDR) && bus.WriteData[0];

  assign busy = !fifo_empty || (state != IDLE);

  logic [31:0] status;
  assign status       = {19'd0, 5'(count), 4'd0, overflow, busy, fifo_empty, fifo_full};
  assign bus.ReadData = (bus.DataAdr == STAT_ADDR) ? status : 32'd0;

  logic unused_wdata;
  assign unused_wdata = ^bus.WriteData[31:8];

  // Storage has no reset; flushing is done through the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Drop has priority over a simultaneous clear.
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            shreg   <= mem[rd_ptr];
`ifdef MMIO_UART_PARITY_EN
            par_q   <= ^mem[rd_ptr];
`endif
            tx      <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (baud_last) begin
            state   <= DATA;
            tx      <= shreg[0];
            baud    <= '0;
            bit_cnt <= '0;
          end else baud <= baud + BW'(1);
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef MMIO_UART_PARITY_EN
              state   <= PARITY;
              tx      <= par_q;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else baud <= baud + BW'(1);
        end
`ifdef MMIO_UART_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            state   <= STOP;
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
          end else baud <= baud + BW'(1);
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud    <= '0;
            bit_cnt <= '0;
            if (pop) begin
              state <= START;
              shreg <= mem[rd_ptr];
`ifdef MMIO_UART_PARITY_EN
              par_q <= ^mem[rd_ptr];
`endif
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else baud <= baud + BW'(1);
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam int          C     = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TXA   = 32'h1000_0000;
  localparam logic [31:0] STA   = 32'h1000_0004;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, busy, overflow;
  int   vectors = 0;
  int   miscompares = 0;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.TX_ADDR(TXA), .STAT_ADDR(STA), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .tx(tx), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  // Reference model: the expected serial line, one entry per clk cycle,
  // starting with the cycle after the first pop edge.
  bit exp_bits[$];

  function automatic void add_frame(input logic [7:0] b);
    for (int c = 0; c < C; c++) exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < C; c++) exp_bits.push_back(b[i]);
`ifdef MMIO_UART_PARITY_EN
    for (int c = 0; c < C; c++) exp_bits.push_back(^b);
`endif
    for (int c = 0; c < C; c++) exp_bits.push_back(1'b1);
  endfunction

  function automatic logic [31:0] status_of(input int n, input bit ov, input bit bz);
    return (32'(n) << 8) | (32'(ov) << 3) | (32'(bz) << 2) |
           (32'(n == 0) << 1) | 32'(n == DEPTH);
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = a;
    bus_if.WriteData = d;
    @(posedge clk); #1;
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = 32'd0;
  endtask

  task automatic test_reset;
    bus_if.DataAdr = STA;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got=%b exp=1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    vectors++; if (bus_if.ReadData !== 32'h2) begin miscompares++; $display("FAIL reset_status got=%h exp=00000002", bus_if.ReadData); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [7:0] bytes [2];
    int pos;
    bytes[0] = 8'h55;
    bytes[1] = 8'($urandom_range(255));
    foreach (bytes[k]) begin
      exp_bits.delete();
      add_frame(bytes[k]);
      store(TXA, {24'd0, bytes[k]});
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_pre got=%b exp=1", tx); end
      pos = -1;
      while (pos < 0) begin @(posedge clk); #1; pos++; end
      while (pos < exp_bits.size()) begin
        vectors++; if (tx !== exp_bits[pos]) begin miscompares++; $display("FAIL single_tx byte=%h pos=%0d got=%b exp=%b", bytes[k], pos, tx, exp_bits[pos]); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy pos=%0d got=%b exp=1", pos, busy); end
        @(posedge clk); #1; pos++;
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_idle got=%b exp=1", tx); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0, b1;
    int pos;
    b0 = 8'($urandom_range(255));
    b1 = 8'($urandom_range(255));
    exp_bits.delete();
    add_frame(b0);
    add_frame(b1);
    store(TXA, {24'd0, b0});
    store(TXA, {24'd0, b1});
    pos = 0;
    while (pos < exp_bits.size()) begin
      vectors++; if (tx !== exp_bits[pos]) begin miscompares++; $display("FAIL b2b_tx pos=%0d got=%b exp=%b", pos, tx, exp_bits[pos]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy pos=%0d got=%b exp=1", pos, busy); end
      @(posedge clk); #1; pos++;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_fall got=%b exp=0", busy); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL b2b_tx_idle got=%b exp=1", tx); end
  endtask

  task automatic test_overflow;
    logic [7:0] mq[$];
    logic [7:0] b;
    bit ov;
    int pos;
    ov = 1'b0;
    exp_bits.delete();
    // Only the edge right after the first store pops; frames are long.
    for (int i = 0; i < 10; i++) begin
      bit pop_now;
      int n_before;
      b = 8'($urandom_range(255));
      pop_now  = (i == 1);
      n_before = mq.size();
      if (pop_now) add_frame(mq.pop_front());
      if (n_before < DEPTH || pop_now) mq.push_back(b);
      else ov = 1'b1;
      store(TXA, {24'd0, b});
    end
    vectors++; if (overflow !== ov) begin miscompares++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ov); end
    bus_if.DataAdr = STA; #1;
    vectors++; if (bus_if.ReadData !== status_of(mq.size(), ov, 1'b1)) begin miscompares++; $display("FAIL ovf_status got=%h exp=%h", bus_if.ReadData, status_of(mq.size(), ov, 1'b1)); end
    bus_if.DataAdr = 32'd0;
    while (mq.size() > 0) add_frame(mq.pop_front());
    pos = 8;
    while (pos < exp_bits.size()) begin
      vectors++; if (tx !== exp_bits[pos]) begin miscompares++; $display("FAIL ovf_tx pos=%0d got=%b exp=%b", pos, tx, exp_bits[pos]); end
      @(posedge clk); #1; pos++;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_fall got=%b exp=0", busy); end
    store(STA, 32'hFFFF_FFFE);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_noclear got=%b exp=1", overflow); end
    store(STA, 32'h1);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    bus_if.DataAdr = STA; #1;
    vectors++; if (bus_if.ReadData !== 32'h2) begin miscompares++; $display("FAIL ovf_status_clr got=%h exp=00000002", bus_if.ReadData); end
    bus_if.DataAdr = 32'd0;
  endtask

  task automatic test_status;
    logic [31:0] other;
    int n, waited;
    other = 32'h1000_0008 + (32'($urandom_range(255)) << 2);
    store(other, 32'($urandom));
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stat_nomatch_busy got=%b exp=0", busy); end
    // Three stores into an idle block: the second edge also pops the first.
    n = 0;
    for (int i = 0; i < 3; i++) begin
      store(TXA, 32'($urandom));
      n = n + 1 - ((i == 1) ? 1 : 0);
    end
    bus_if.DataAdr = STA; #1;
    vectors++; if (bus_if.ReadData !== status_of(n, 1'b0, 1'b1)) begin miscompares++; $display("FAIL stat_count got=%h exp=%h", bus_if.ReadData, status_of(n, 1'b0, 1'b1)); end
    bus_if.DataAdr = TXA; #1;
    vectors++; if (bus_if.ReadData !== 32'd0) begin miscompares++; $display("FAIL stat_txaddr got=%h exp=0", bus_if.ReadData); end
    bus_if.DataAdr = other; #1;
    vectors++; if (bus_if.ReadData !== 32'd0) begin miscompares++; $display("FAIL stat_other got=%h exp=0", bus_if.ReadData); end
    bus_if.DataAdr = 32'd0;
    waited = 0;
    while (busy === 1'b1 && waited < 40 * C) begin @(posedge clk); #1; waited++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stat_drain_timeout got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midframe;
    store(TXA, 32'h0);
    store(TXA, 32'($urandom));
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pre got=%b exp=0", tx); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 12 * C; i++) begin
      @(posedge clk); #1;
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_residual_tx cyc=%0d got=%b exp=1", i, tx); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_residual_busy got=%b exp=0", busy); end
    bus_if.DataAdr = STA; #1;
    vectors++; if (bus_if.ReadData !== 32'h2) begin miscompares++; $display("FAIL rst_status got=%h exp=00000002", bus_if.ReadData); end
    bus_if.DataAdr = 32'd0;
  endtask

`ifdef MMIO_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes [2];
    int pos;
    bytes[0] = 8'h07;
    bytes[1] = 8'h03;
    foreach (bytes[k]) begin
      exp_bits.delete();
      add_frame(bytes[k]);
      store(TXA, {24'd0, bytes[k]});
      pos = -1;
      while (pos < 0) begin @(posedge clk); #1; pos++; end
      while (pos < 11 * C) begin
        vectors++; if (tx !== exp_bits[pos]) begin miscompares++; $display("FAIL parity_tx byte=%h pos=%0d got=%b exp=%b", bytes[k], pos, tx, exp_bits[pos]); end
        @(posedge clk); #1; pos++;
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_len byte=%h busy=%b exp=0", bytes[k], busy); end
    end
  endtask
`endif

  initial begin
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = 32'd0;
    bus_if.WriteData = 32'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_status();
    test_reset_midframe();
`ifdef MMIO_UART_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle RISC-V core's data bus, downstream of `top`. It decodes the `MemWrite`/`DataAdr`/`WriteData` store stream, queues byte writes in a small FIFO, and serialises them 8N1 on `tx`. A status word is returned on `ReadData`, so firmware can poll for completion and benches can check a program's output stream instead of peeking register-file internals.

## Interface
- `TX_ADDR`, default 32'h1000_0000: write address of the data register; a store pushes `WriteData[7:0]`.
- `STAT_ADDR`, default 32'h1000_0004: status register address, readable; a write with bit0=1 clears overflow.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit, ≥2.
- `FIFO_DEPTH`, default 8: power of two, 2..16.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `MemWrite`  in  1  store strobe from core.
- `DataAdr`  in  32  bus address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  status word when `DataAdr==STAT_ADDR`, else 0 (combinational).
- `tx`  out  1  serial output, idle high, registered.
- `busy`  out  1  FIFO non-empty or frame in progress.
- `overflow`  out  1  sticky drop flag.

## Operation
- Push: `MemWrite && DataAdr==TX_ADDR` at a rising edge. Accepted if count<FIFO_DEPTH or a pop occurs on the same edge; otherwise the byte is dropped and `overflow` is set.
- Clear: `MemWrite && DataAdr==STAT_ADDR && WriteData[0]` clears `overflow`. A simultaneous drop wins; overflow stays 1.
- Status word: bit0 full, bit1 empty, bit2 `busy`, bit3 `overflow`, bits[12:8] count, all other bits 0.
- FSM states are IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE→START when the FIFO is non-empty. This pops the head into the shift register.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, go to START with a pop if the FIFO is non-empty, else go to IDLE. There is no inter-frame gap.
- A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) both reset to 0 on every state entry.
- Non-matching addresses and reads have no effect.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, FIFO empty (count 0), FSM IDLE, counters 0, `ReadData` at STAT_ADDR = 32'h0000_0002.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), the frame is aborted and the FIFO is flushed.
- Latency:
  - A push at edge N into an idle, empty block pops at edge N+1.
  - `tx` falls after edge N+1.
  - `busy` rises after edge N.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- `busy` falls after the final STOP edge when the FIFO is empty.
- Push and pop on the same edge: count unchanged, byte accepted even when full.

## Configuration
- `MMIO_UART_PARITY_EN`
  - Defined: a PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Undefined: DATA goes straight to STOP, and no parity logic exists.

## Test plan
- Single byte (CLKS_PER_BIT=4): store 0x55 to TX_ADDR -> `tx` low at +1 edge, then 1,0,1,0,1,0,1,0 each 4 cycles, then stop high; `busy` low after 40 cycles.
- Back-to-back: stores 0x41 then 0x42 on consecutive cycles -> 80 contiguous frame cycles, second start bit immediately after first stop, no idle cycle.
- Overflow (depth 8): 10 stores on consecutive cycles -> 9 bytes transmitted, 10th dropped, `overflow`=1, status bit3=1. A store of 1 to STAT_ADDR -> `overflow`=0.
- Status readback: after reset `ReadData`=0x0000_0002. After 3 stores while busy -> count field reflects the FIFO (2 after the first pop), bit2=1. `ReadData`=0 at other addresses.
- Reset mid-frame: drop `reset` during DATA -> `tx`=1 with no clock edge needed, `busy`=0. After release, no residual bytes are sent.
- With `MMIO_UART_PARITY_EN`: send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.
